// File: rtl/sw_gain_pkg.sv
// Shared types and defaults for the switch-to-preamp gain controller.
// Holds the SPI FSM state type, frame width and parameter defaults.
package sw_gain_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD
    } state_t;

    localparam int FRAME_BITS = 8;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_SPI_DIV = 4;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus debouncer for a bus of raw switches.
// Ports: clk, rst_n, din (raw), stable (debounced), changed (pulse).
module sw_debounce
    import sw_gain_pkg::*;
#(
    parameter int W = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] stable,
    output logic         changed
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [W-1:0]  s1;
    logic [W-1:0]  s2;
    logic [W-1:0]  cand;
    logic [CW-1:0] cnt;
    logic          cnt_end;

    assign cnt_end = (cnt == CW'(DEBOUNCE_CYCLES - 1));

    // Commit when the same candidate has persisted long enough.
    assign changed = (s2 != stable) && (s2 == cand) && cnt_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= '0;
            s2     <= '0;
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == stable) begin
                cand <= s2;
                cnt  <= '0;
            end else if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt_end) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sw_gain_ctrl.sv
// Debounced switches drive a mode-0 SPI write of {sw,sw} to a preamp.
// Ports: CLK50MHZ, RST_N, SW, AMP_CS, SPI_SCK, SPI_MOSI, AMP_SHDN,
// busy, gain, done; AMP_MISO/rb_byte with SW_GAIN_READBACK_EN.
module sw_gain_ctrl
    import sw_gain_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SPI_DIV = DEF_SPI_DIV
) (
    input  logic       CLK50MHZ,
    input  logic       RST_N,
    input  logic [3:0] SW,
`ifdef SW_GAIN_READBACK_EN
    input  logic       AMP_MISO,
    output logic [7:0] rb_byte,
`endif
    output logic       AMP_CS,
    output logic       SPI_SCK,
    output logic       SPI_MOSI,
    output logic       AMP_SHDN,
    output logic       busy,
    output logic [3:0] gain,
    output logic       done
);

    localparam int DW = $clog2(SPI_DIV) + 1;
    localparam int BW = $clog2(FRAME_BITS);

    state_t                state;
    state_t                state_n;
    logic [3:0]            stable;
    logic                  chg;
    logic                  pending;
    logic [DW-1:0]         div_cnt;
    logic                  div_end;
    logic                  phase;
    logic [BW-1:0]         bit_idx;
    logic [FRAME_BITS-1:0] shreg;
    logic [3:0]            lo;
`ifdef SW_GAIN_READBACK_EN
    logic [FRAME_BITS-1:0] rb_sh;
`endif

    sw_debounce #(
        .W(4),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk(CLK50MHZ),
        .rst_n(RST_N),
        .din(SW),
        .stable(stable),
        .changed(chg)
    );

    assign div_end = (div_cnt == DW'(SPI_DIV - 1));
    assign AMP_SHDN = 1'b0;

    always_ff @(posedge CLK50MHZ or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:     if (pending) state_n = CS_SETUP;
            CS_SETUP: if (div_end) state_n = SHIFT;
            SHIFT:
                if (div_end && phase &&
                    bit_idx == BW'(FRAME_BITS - 1))
                    state_n = CS_HOLD;
            CS_HOLD:  if (div_end) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_comb begin
        AMP_CS   = (state == IDLE);
        busy     = (state != IDLE);
        SPI_SCK  = (state == SHIFT) && phase;
        SPI_MOSI = (state != IDLE) && shreg[FRAME_BITS-1];
    end

    always_ff @(posedge CLK50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            pending <= 1'b1;
            div_cnt <= '0;
            phase   <= 1'b0;
            bit_idx <= '0;
            shreg   <= '0;
            lo      <= '0;
            gain    <= '0;
            done    <= 1'b0;
`ifdef SW_GAIN_READBACK_EN
            rb_sh   <= '0;
            rb_byte <= '0;
`endif
        end else begin
            done <= 1'b0;
            // A change arriving as a frame starts re-arms pending.
            pending <= (pending && state != IDLE) || chg;
            if (state == IDLE || div_end) div_cnt <= '0;
            else                          div_cnt <= div_cnt + 1'b1;
            unique case (state)
                IDLE:
                    if (pending) begin
                        shreg   <= {stable, stable};
                        lo      <= stable;
                        phase   <= 1'b0;
                        bit_idx <= '0;
                    end
                SHIFT:
                    if (div_end) begin
                        phase <= ~phase;
                        if (phase) begin
                            shreg   <= shreg << 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
`ifdef SW_GAIN_READBACK_EN
                        else begin
                            rb_sh <= {rb_sh[FRAME_BITS-2:0], AMP_MISO};
                        end
`endif
                    end
                CS_HOLD:
                    if (div_end) begin
                        gain <= lo;
                        done <= 1'b1;
`ifdef SW_GAIN_READBACK_EN
                        rb_byte <= rb_sh;
`endif
                    end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sw_gain_ctrl.sv
// Directed scoreboard bench for sw_gain_ctrl (DEBOUNCE_CYCLES=16, SPI_DIV=2).
// Readback checks are built when SW_GAIN_READBACK_EN is defined.
module tb_sw_gain_ctrl;

    localparam int D = 2;
    localparam int DB = 16;

    logic       CLK50MHZ = 1'b0;
    logic       RST_N;
    logic [3:0] SW;
    logic       AMP_CS;
    logic       SPI_SCK;
    logic       SPI_MOSI;
    logic       AMP_SHDN;
    logic       busy;
    logic [3:0] gain;
    logic       done;
    logic [7:0] rbv;
`ifdef SW_GAIN_READBACK_EN
    logic       AMP_MISO;
    logic [7:0] rb_byte;
    logic [7:0] rb_pat = 8'hC5;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] b;
        int         len;
        logic       dn;
        logic [3:0] g;
        int         bits;
        logic       rbad;
        logic [7:0] rb;
    } frame_t;

    typedef struct {
        logic [7:0] b;
        logic [3:0] g;
    } exp_t;

    frame_t obs_q[$];
    exp_t   exp_q[$];

    sw_gain_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .SPI_DIV(D)
    ) dut (
        .CLK50MHZ(CLK50MHZ),
        .RST_N(RST_N),
        .SW(SW),
`ifdef SW_GAIN_READBACK_EN
        .AMP_MISO(AMP_MISO),
        .rb_byte(rb_byte),
`endif
        .AMP_CS(AMP_CS),
        .SPI_SCK(SPI_SCK),
        .SPI_MOSI(SPI_MOSI),
        .AMP_SHDN(AMP_SHDN),
        .busy(busy),
        .gain(gain),
        .done(done)
    );

    always #10 CLK50MHZ = ~CLK50MHZ;

    logic       prev_cs = 1'b1;
    logic       prev_sck = 1'b0;
    logic       in_frame = 1'b0;
    int         len = 0;
    int         mon_bits = 8;
    logic [7:0] sh = '0;
    logic       rbad = 1'b0;
    int         done_cnt = 0;
    int         frame_cnt = 0;

`ifdef SW_GAIN_READBACK_EN
    assign rbv = rb_byte;
    always_comb begin
        AMP_MISO = 1'b0;
        if (mon_bits < 8) AMP_MISO = rb_pat[7 - mon_bits];
    end
`else
    assign rbv = 8'h00;
`endif

    function automatic frame_t mk(logic [7:0] b, int l, logic dn,
                                  logic [3:0] g, int bits,
                                  logic rb_bad, logic [7:0] rb);
        frame_t f;
        f.b = b; f.len = l; f.dn = dn; f.g = g;
        f.bits = bits; f.rbad = rb_bad; f.rb = rb;
        return f;
    endfunction

    always @(negedge CLK50MHZ) begin
        prev_cs  <= AMP_CS;
        prev_sck <= SPI_SCK;
        if (done) done_cnt <= done_cnt + 1;
        if (!RST_N) begin
            in_frame <= 1'b0;
            mon_bits <= 8;
        end else if (prev_cs && !AMP_CS) begin
            in_frame <= 1'b1;
            len      <= 1;
            mon_bits <= 0;
            sh       <= '0;
            rbad     <= 1'b0;
        end else if (in_frame) begin
            if (!AMP_CS) begin
                len <= len + 1;
                if (!prev_sck && SPI_SCK) begin
                    sh       <= {sh[6:0], SPI_MOSI};
                    mon_bits <= mon_bits + 1;
                    if (len + 1 != 2*D + 1 + 2*D*mon_bits) rbad <= 1'b1;
                end
            end else begin
                obs_q.push_back(mk(sh, len, done, gain, mon_bits, rbad, rbv));
                in_frame  <= 1'b0;
                frame_cnt <= frame_cnt + 1;
            end
        end
    end

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge CLK50MHZ);
        #2;
    endtask

    task automatic expect_frame(logic [7:0] b, logic [3:0] g);
        exp_t e;
        e.b = b;
        e.g = g;
        exp_q.push_back(e);
    endtask

    task automatic check_frame(string tag);
        int t = 0;
        frame_t f;
        exp_t e;
        while (obs_q.size() == 0 && t < 400) begin
            @(posedge CLK50MHZ);
            t++;
        end
        if (obs_q.size() == 0) begin
            chk({tag, "_timeout"}, 0, 1);
            return;
        end
        f = obs_q.pop_front();
        e = exp_q.pop_front();
        chk({tag, "_byte"}, f.b, e.b);
        chk({tag, "_cs_len"}, f.len, 18*D);
        chk({tag, "_done"}, f.dn, 1'b1);
        chk({tag, "_gain"}, f.g, e.g);
        chk({tag, "_bits"}, f.bits, 8);
        chk({tag, "_sck_mid"}, f.rbad, 1'b0);
`ifdef SW_GAIN_READBACK_EN
        chk({tag, "_rb"}, f.rb, 8'hC5);
`endif
    endtask

    task automatic wait_busy(string tag);
        int t = 0;
        while (!busy && t < 200) begin
            @(posedge CLK50MHZ);
            t++;
        end
        #2;
        chk({tag, "_busy_seen"}, busy, 1'b1);
    endtask

    initial begin
        RST_N = 1'b0;
        SW = 4'h0;
        cyc(4);
        @(negedge CLK50MHZ);
        chk("rst_cs", AMP_CS, 1'b1);
        chk("rst_sck", SPI_SCK, 1'b0);
        chk("rst_mosi", SPI_MOSI, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_gain", gain, 4'h0);
        chk("rst_done", done, 1'b0);
        chk("shdn", AMP_SHDN, 1'b0);
`ifdef SW_GAIN_READBACK_EN
        chk("rst_rb", rb_byte, 8'h00);
`endif

        expect_frame(8'h00, 4'h0);
        RST_N = 1'b1;
        check_frame("f00");
        cyc(80);
        chk("no_extra_after_rst", obs_q.size(), 0);
        chk("idle_busy", busy, 1'b0);

        SW = 4'h3;
        expect_frame(8'h33, 4'h3);
        check_frame("f33");
        cyc(10);
        chk("gain_3", gain, 4'h3);

        SW = 4'h5;
        cyc(10);
        SW = 4'h3;
        cyc(100);
        chk("glitch_no_frame", obs_q.size(), 0);
        chk("glitch_gain", gain, 4'h3);

        SW = 4'h7;
        expect_frame(8'h77, 4'h7);
        wait_busy("f77");
        SW = 4'hA;
        expect_frame(8'hAA, 4'hA);
        check_frame("f77");
        check_frame("fAA");
        cyc(100);
        chk("one_follow_up", obs_q.size(), 0);
        chk("gain_A", gain, 4'hA);

        SW = 4'h6;
        wait_busy("f66");
        begin
            int t = 0;
            while (mon_bits != 4 && t < 200) begin
                @(posedge CLK50MHZ);
                t++;
            end
            chk("reach_bit4", mon_bits, 4);
        end
        @(posedge CLK50MHZ);
        #2;
        RST_N = 1'b0;
        #1;
        chk("abort_cs", AMP_CS, 1'b1);
        chk("abort_sck", SPI_SCK, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_gain", gain, 4'h0);
        SW = 4'h0;
        cyc(5);
        chk("abort_no_frame", obs_q.size(), 0);
        expect_frame(8'h00, 4'h0);
        RST_N = 1'b1;
        check_frame("f00b");
        cyc(100);
        chk("post_abort_idle", obs_q.size(), 0);
        chk("done_pulses", done_cnt, frame_cnt);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
